out_port_fifo: RTL and testbench
================================

# out_port_fifo

Output-port buffer that sits directly downstream of the processor's `out` port. It captures every OUT write issued by the execute stage, queues the values in a small FIFO, and drains them to an external consumer over a valid/ready handshake, so a slow peripheral never loses or stalls OUT results. It also keeps a registered copy of the most recent accepted value, and flags dropped writes with a sticky overflow bit.

## Interface
Parameters:
- `DEPTH`, 4: number of FIFO entries. Must be a power of two, ≥2.
- `WIDTH`, 16: data width. Matches the processor data path.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `i_write`  in  1  — OUT write strobe from the pipeline (execute-stage output-write control).
- `i_data`  in  WIDTH  — value to output (execute-stage ALU result).
- `o_full`  out  1  — FIFO holds DEPTH entries.
- `o_valid`  out  1  — head entry available to the consumer.
- `i_ready`  in  1  — consumer accepts the head entry this cycle.
- `o_data`  out  WIDTH  — head entry; 0 when `o_valid`=0.
- `o_count`  out  $clog2(DEPTH+1)  — current occupancy.
- `o_last`  out  WIDTH  — last accepted write value (processor-visible OUT register).
- `o_overflow`  out  1  — sticky: a write was dropped.
- `i_clr_ovf`  in  1  — synchronous clear of `o_overflow`.

## Operation
- Storage: DEPTH×WIDTH register array, write pointer `wp`, read pointer `rp`, counter `cnt`. Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH naturally.
- Pop:
  - `pop` = `o_valid` & `i_ready`.
  - On pop, `rp` increments.
  - `i_ready` while `o_valid`=0 has no effect.
- Push:
  - `push` = `i_write` & (!`o_full` | `pop`).
  - On push, `mem[wp]`←`i_data`, `wp` increments, and `o_last`←`i_data`.
- Drop:
  - `i_write` & `o_full` & !`pop` drops the write.
  - On a drop: `o_overflow`←1, and `o_last`, `mem`, and the pointers are unchanged.
- Counter:
  - `cnt` increments on push-only, decrements on pop-only, and is unchanged on push+pop or on neither.
  - `o_count`=`cnt`, `o_full`=(`cnt`==DEPTH), `o_valid`=(`cnt`!=0).
- Head data: `o_data`=`mem[rp]` gated to 0 when empty. This is a combinational read of registered storage, i.e. fall-through: no extra output register.
- Overflow clear:
  - `i_clr_ovf` clears `o_overflow` at the next edge.
  - If a drop occurs in the same cycle, set wins: `o_overflow`=1.
- Reset (`rst`=0, asynchronous): `wp`=`rp`=`cnt`=0, `o_overflow`=0, `o_last`=0.
  - Resulting outputs: `o_valid`=0, `o_full`=0, `o_data`=0, `o_count`=0.
  - Array contents need not be reset.
  - Reset mid-transfer discards all queued entries.
  - First edge after release operates normally.
- Handshake rule: the consumer may change `i_ready` freely. Once `o_valid`=1, `o_valid` and `o_data` stay stable until a pop or a reset.

## Timing
- Write-to-visible latency is 1 cycle: a push at edge N gives `o_valid`=1 and `o_data`=value after edge N, when the FIFO was empty.
- Pop takes effect at the edge where `o_valid`&`i_ready`. The next entry, or `o_valid`=0, appears after that edge.
- Full + push + pop in the same cycle: accepted, `cnt` stays DEPTH, and no overflow.
- Empty + `i_write` + `i_ready`: write accepted and no pop that cycle. No bypass: data reaches the consumer one cycle later.
- Throughput: one push and one pop per cycle sustained.
- All outputs are derived from registers only. No combinational path from `i_write`/`i_data` to any output.
- `i_ready` reaches no output combinationally.

## Test plan
- Reset/idle:
  - Stimulus: assert `rst`=0 mid-run with `cnt`=3, then release.
  - Required: immediately `o_valid`=0, `o_count`=0, `o_data`=0, `o_last`=0, `o_overflow`=0.
- Single pass-through:
  - Stimulus: `i_write`=1, `i_data`=16'h00A5 for one cycle, `i_ready`=0.
  - Required: next cycle `o_valid`=1, `o_data`=16'h00A5, `o_last`=16'h00A5, `o_count`=1.
  - Then `i_ready`=1 for one cycle → `o_valid`=0, `o_count`=0.
- Fill and overflow (DEPTH=4):
  - Stimulus: write 1,2,3,4,5 on consecutive cycles with `i_ready`=0.
  - Required: `o_full`=1 after the 4th write, `o_overflow`=1 after the 5th, `o_last`=4, `o_data`=1.
  - Then drain with `i_ready`=1 → consumer sees exactly 1,2,3,4.
- Full simultaneous push/pop:
  - Stimulus: with FIFO full of 1..4, `i_write`=1, `i_data`=9, `i_ready`=1.
  - Required: `o_overflow` stays 0, `o_count`=4, drained order is 2,3,4,9.
- Wrap-around streaming:
  - Stimulus: 20 consecutive writes 0..19 with `i_ready` toggling 1,0,1,1 pattern.
  - Required: output sequence exactly 0..19, no overflow, `o_count` never exceeds 4.
- Overflow clear priority:
  - Stimulus: in full state, assert `i_clr_ovf`=1 with a dropped write → `o_overflow` stays 1.
  - Next cycle `i_clr_ovf`=1 with no write → `o_overflow`=0.

Source files
------------

// File: rtl/out_port_fifo.sv
// Output-port buffer behind the processor OUT port: fall-through FIFO drained over valid/ready,
// plus a registered copy of the last accepted write and a sticky overflow flag for dropped writes.
module out_port_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_write,
    input  logic [WIDTH-1:0]           i_data,
    output logic                       o_full,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic [WIDTH-1:0]           o_last,
    output logic                       o_overflow,
    input  logic                       i_clr_ovf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic [CNT_W-1:0] cnt;
    logic             pop;
    logic             push;
    logic             drop;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    always_comb begin
        pop  = o_valid & i_ready;
        push = i_write & (~o_full | pop);
        drop = i_write & o_full & ~pop;
    end

    assign o_count = cnt;
    assign o_full  = (cnt == CNT_W'(DEPTH));
    assign o_valid = (cnt != '0);
    assign o_data  = o_valid ? mem[rp] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp         <= '0;
            rp         <= '0;
            cnt        <= '0;
            o_last     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push) begin
                wp     <= wp + PTR_W'(1);
                o_last <= i_data;
            end
            if (pop) begin
                rp <= rp + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                o_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_out_port_fifo.sv
// Scoreboard bench for out_port_fifo: directed writes queue their expected drain values,
// a negedge monitor compares every handshake against the queue.
module tb_out_port_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 16;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       i_write;
    logic [WIDTH-1:0]           i_data;
    logic                       o_full;
    logic                       o_valid;
    logic                       i_ready;
    logic [WIDTH-1:0]           o_data;
    logic [$clog2(DEPTH+1)-1:0] o_count;
    logic [WIDTH-1:0]           o_last;
    logic                       o_overflow;
    logic                       i_clr_ovf;

    int vectors    = 0;
    int miscompares = 0;
    logic [WIDTH-1:0] sb[$];

    out_port_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_write   (i_write),
        .i_data    (i_data),
        .o_full    (o_full),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_count   (o_count),
        .o_last    (o_last),
        .o_overflow(o_overflow),
        .i_clr_ovf (i_clr_ovf)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so at negedge valid&ready means a pop at the coming edge.
    always @(negedge clk) begin
        if (rst && o_valid && i_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL drain: got %h with nothing expected", o_data);
            end else begin
                logic [WIDTH-1:0] exp;
                exp = sb.pop_front();
                if (o_data !== exp) begin
                    miscompares++;
                    $display("FAIL drain: got %h, expected %h", o_data, exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [WIDTH-1:0] d, input bit accepted);
        i_write = 1'b1;
        i_data  = d;
        if (accepted) sb.push_back(d);
        tick();
        i_write = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done    = 1'b0;
        i_ready = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            tick();
            if (!o_valid) done = 1'b1;
        end
        i_ready = 1'b0;
        chk({name, "_drained"}, 32'(done), 32'd1);
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] readyPat;
        int         nextVal;
        int         budget;
        readyPat  = 4'b1101; // bit k = ready in cycle k%4: 1,0,1,1
        rst       = 1'b0;
        i_write   = 1'b0;
        i_data    = '0;
        i_ready   = 1'b0;
        i_clr_ovf = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Idle after reset
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);

        // Single pass-through
        wr(16'h00A5, 1'b1);
        chk("pt_valid", 32'(o_valid), 32'd1);
        chk("pt_data", 32'(o_data), 32'h00A5);
        chk("pt_last", 32'(o_last), 32'h00A5);
        chk("pt_count", 32'(o_count), 32'd1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("pt_valid_after", 32'(o_valid), 32'd0);
        chk("pt_count_after", 32'(o_count), 32'd0);
        chk("pt_data_after", 32'(o_data), 32'd0);

        // Fill and overflow
        for (int v = 1; v <= 5; v++) begin
            wr(WIDTH'(v), v <= 4);
            if (v == 3) chk("fill_full_at3", 32'(o_full), 32'd0);
            if (v == 4) chk("fill_full_at4", 32'(o_full), 32'd1);
            if (v == 4) chk("fill_ovf_at4", 32'(o_overflow), 32'd0);
        end
        chk("ovf_set", 32'(o_overflow), 32'd1);
        chk("ovf_last", 32'(o_last), 32'd4);
        chk("ovf_data", 32'(o_data), 32'd1);
        chk("ovf_count", 32'(o_count), 32'd4);
        drain("fill");
        i_clr_ovf = 1'b1;
        tick();
        i_clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(o_overflow), 32'd0);

        // Full with simultaneous push and pop
        for (int v = 1; v <= 4; v++) wr(WIDTH'(v), 1'b1);
        i_ready = 1'b1;
        wr(16'd9, 1'b1);
        i_ready = 1'b0;
        chk("pp_ovf", 32'(o_overflow), 32'd0);
        chk("pp_count", 32'(o_count), 32'd4);
        chk("pp_full", 32'(o_full), 32'd1);
        chk("pp_head", 32'(o_data), 32'd2);
        chk("pp_last", 32'(o_last), 32'd9);
        drain("pp");

        // Clear versus drop in the same cycle
        for (int v = 5; v <= 8; v++) wr(WIDTH'(v), 1'b1);
        i_clr_ovf = 1'b1;
        wr(16'h0055, 1'b0);
        chk("clr_drop_ovf", 32'(o_overflow), 32'd1);
        chk("clr_drop_last", 32'(o_last), 32'd8);
        chk("clr_drop_count", 32'(o_count), 32'd4);
        tick();
        i_clr_ovf = 1'b0;
        chk("clr_only_ovf", 32'(o_overflow), 32'd0);
        drain("clr");

        // Wrap-around streaming with ready 1,0,1,1; producer holds off while full and not popping
        nextVal = 0;
        budget  = 0;
        while (nextVal < 20 && budget < 200) begin
            i_ready = readyPat[budget % 4];
            if (!o_full || i_ready) begin
                i_write = 1'b1;
                i_data  = WIDTH'(nextVal);
                sb.push_back(WIDTH'(nextVal));
                nextVal++;
            end else begin
                i_write = 1'b0;
            end
            tick();
            if (o_count > 3'(DEPTH)) chk("stream_count_bound", 32'(o_count), 32'(DEPTH));
            budget++;
        end
        i_write = 1'b0;
        i_ready = 1'b0;
        chk("stream_all_written", 32'(nextVal), 32'd20);
        chk("stream_ovf", 32'(o_overflow), 32'd0);
        drain("stream");

        // Asynchronous reset mid-run with three entries queued and overflow set
        for (int v = 1; v <= 4; v++) wr(WIDTH'(16'h0011 * v), 1'b1);
        wr(16'h0055, 1'b0);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("mid_count", 32'(o_count), 32'd3);
        chk("mid_ovf", 32'(o_overflow), 32'd1);
        rst = 1'b0;
        sb.delete();
        #2;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_count", 32'(o_count), 32'd0);
        chk("arst_data", 32'(o_data), 32'd0);
        chk("arst_last", 32'(o_last), 32'd0);
        chk("arst_ovf", 32'(o_overflow), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        wr(16'h0077, 1'b1);
        chk("post_rst_valid", 32'(o_valid), 32'd1);
        chk("post_rst_data", 32'(o_data), 32'h0077);
        chk("post_rst_count", 32'(o_count), 32'd1);
        drain("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
